// File: rtl/uart_wide.sv
// uart_wide - parametrised full-duplex UART.
//   Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
//   RX is 16x oversampled, sampling each bit at sub-tick 7 (mid-bit).
//   Optional feature macro: UART_WIDE_PARITY_EN compiles in the parity
//   generator/checker; without it PARITY is ignored and parity_error is 0.
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   rx / tx         serial in (2-flop synchronised) / serial out, idle high
//   transmit        start request, accepted only while idle
//   tx_data         word to send, latched on acceptance
//   received        1-cycle pulse, rx_data holds the new word
//   rx_data         last good word
//   is_receiving    RX frame in progress
//   is_transmitting TX frame in progress
//   recv_error      1-cycle pulse, a stop bit was sampled low
//   parity_error    1-cycle pulse, parity mismatch with good stop bits
module uart_wide #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 16,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 received,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 is_receiving,
    output logic                 is_transmitting,
    output logic                 recv_error,
    output logic                 parity_error
);
    localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
    localparam logic [6:0]    DATA_LAST = 7'(DATA_BITS - 1);
    localparam logic [6:0]    STOP_LAST = 7'(STOP_BITS - 1);
`ifdef UART_WIDE_PARITY_EN
    localparam bit PAR_ON  = (PARITY != 0);
    localparam bit PAR_ODD = (PARITY == 2);
`else
    localparam bit PAR_ON  = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Shared free-running oversample tick and rx synchroniser
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter. It restarts its own prescaler on acceptance so that
    // every bit lasts exactly 16*BAUD_DIV cycles regardless of the phase
    // of the shared tick.
    // ------------------------------------------------------------------
    state_t               tx_state_q, tx_state_d;
    logic [DW-1:0]        tx_div_q, tx_div_d;
    logic [3:0]           tx_sub_q, tx_sub_d;
    logic [6:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_tick, tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_sub_d   = tx_sub_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_tick    = (tx_div_q == DIV_LAST);
        tx_bit_end = tx_tick && (tx_sub_q == 4'd15);
        if (tx_state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (transmit) begin
                tx_state_d = S_START;
                tx_d       = 1'b0;
                tx_div_d   = '0;
                tx_sub_d   = '0;
                tx_idx_d   = '0;
                tx_shift_d = tx_data;
`ifdef UART_WIDE_PARITY_EN
                tx_par_d   = PAR_ODD ^ (^tx_data);
`else
                tx_par_d   = 1'b0;
`endif
            end
        end else begin
            tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
            if (tx_tick) tx_sub_d = tx_sub_q + 4'd1;
            if (tx_bit_end) begin
                case (tx_state_q)
                    S_START: begin
                        tx_state_d = S_DATA;
                        tx_d       = tx_shift_q[0];
                    end
                    S_DATA: begin
                        if (tx_idx_q == DATA_LAST) begin
                            tx_idx_d = '0;
                            if (PAR_ON) begin
                                tx_state_d = S_PARITY;
                                tx_d       = tx_par_q;
                            end else begin
                                tx_state_d = S_STOP;
                                tx_d       = 1'b1;
                            end
                        end else begin
                            // shift out LSB first; next bit is shift[1]
                            tx_idx_d   = tx_idx_q + 7'd1;
                            tx_shift_d = tx_shift_q >> 1;
                            tx_d       = tx_shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end
                    S_STOP: begin
                        if (tx_idx_q == STOP_LAST) tx_state_d = S_IDLE;
                        else                       tx_idx_d   = tx_idx_q + 7'd1;
                        tx_d = 1'b1;
                    end
                    default: tx_state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_div_q   <= '0;
            tx_sub_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_sub_q   <= tx_sub_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver. START waits 8 ticks to reach mid-bit; every later bit is
    // sampled 16 ticks after the previous sample (sub-tick wraps 15->0).
    // A new frame needs a falling edge, so after a framing error the line
    // must return high before the receiver re-arms.
    // ------------------------------------------------------------------
    state_t               rx_state_q, rx_state_d;
    logic [3:0]           rx_sub_q, rx_sub_d;
    logic [6:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 par_bad_q, par_bad_d;
    logic                 received_q, received_d;
    logic                 recv_error_q, recv_error_d;
    logic                 parity_error_q, parity_error_d;
    logic                 rx_sample;

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_sub_d       = rx_sub_q;
        rx_idx_d       = rx_idx_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        par_bad_d      = par_bad_q;
        received_d     = 1'b0;
        recv_error_d   = 1'b0;
        parity_error_d = 1'b0;
        rx_sample      = tick && ((rx_state_q == S_START) ? (rx_sub_q == 4'd7)
                                                          : (rx_sub_q == 4'd15));
        if (rx_state_q != S_IDLE && tick) rx_sub_d = rx_sub_q + 4'd1;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_sub_d   = '0;
                    rx_idx_d   = '0;
                    par_bad_d  = 1'b0;
                end
            end
            S_START: begin
                if (rx_sample) begin
                    // line back high at mid start bit: glitch, drop silently
                    if (rx_s2_q) rx_state_d = S_IDLE;
                    else begin
                        rx_state_d = S_DATA;
                        rx_sub_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) begin
                        rx_idx_d = '0;
                        if (PAR_ON) rx_state_d = S_PARITY;
                        else        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 7'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_sample) begin
`ifdef UART_WIDE_PARITY_EN
                    par_bad_d = rx_s2_q ^ PAR_ODD ^ (^rx_shift_q);
`endif
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample) begin
                    if (!rx_s2_q) begin
                        recv_error_d = 1'b1;
                        rx_state_d   = S_IDLE;
                    end else if (rx_idx_q == STOP_LAST) begin
                        rx_state_d = S_IDLE;
                        if (par_bad_q) parity_error_d = 1'b1;
                        else begin
                            received_d = 1'b1;
                            rx_data_d  = rx_shift_q;
                        end
                    end else begin
                        rx_idx_d = rx_idx_q + 7'd1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q     <= S_IDLE;
            rx_sub_q       <= '0;
            rx_idx_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            par_bad_q      <= 1'b0;
            received_q     <= 1'b0;
            recv_error_q   <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_sub_q       <= rx_sub_d;
            rx_idx_q       <= rx_idx_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            par_bad_q      <= par_bad_d;
            received_q     <= received_d;
            recv_error_q   <= recv_error_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign tx              = tx_q;
    assign is_transmitting = (tx_state_q != S_IDLE);
    assign is_receiving    = (rx_state_q != S_IDLE);
    assign received        = received_q;
    assign rx_data         = rx_data_q;
    assign recv_error      = recv_error_q;
`ifdef UART_WIDE_PARITY_EN
    assign parity_error    = parity_error_q;
`else
    assign parity_error    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wide.sv
// Bench for uart_wide: DUT A (8 bits, BAUD_DIV=2, 1 stop, even parity if
// enabled) with switchable loopback; DUT B (64 bits, BAUD_DIV=1, 2 stops,
// odd parity if enabled) permanently looped back.
module tb_uart_wide;
`ifdef UART_WIDE_PARITY_EN
    localparam int PON = 1;
`else
    localparam int PON = 0;
`endif
    localparam int BA = 2;
    localparam int TA = 16 * BA;
    localparam int NA = 1 + 8 + PON + 1;
    localparam int NB = 1 + 64 + PON + 2;

    logic clk = 1'b0;
    logic rst;
    logic rx_drv, loop_a;
    logic transmit_a, transmit_b;
    logic [7:0]  tx_data_a, rx_data_a;
    logic [63:0] tx_data_b, rx_data_b;
    logic tx_a, rx_a, received_a, is_receiving_a, is_transmitting_a, recv_error_a, parity_error_a;
    logic tx_b, received_b, is_receiving_b, is_transmitting_b, recv_error_b, parity_error_b;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_rcv_a = 0, n_err_a = 0, n_perr_a = 0, n_isrx_a = 0, t_rcv_a = 0;
    int n_rcv_b = 0, n_err_b = 0, n_perr_b = 0;

    assign rx_a = loop_a ? tx_a : rx_drv;

    uart_wide #(.DATA_BITS(8), .BAUD_DIV(BA), .STOP_BITS(1), .PARITY(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .transmit(transmit_a), .tx_data(tx_data_a),
        .received(received_a), .rx_data(rx_data_a), .is_receiving(is_receiving_a),
        .is_transmitting(is_transmitting_a), .recv_error(recv_error_a), .parity_error(parity_error_a));

    uart_wide #(.DATA_BITS(64), .BAUD_DIV(1), .STOP_BITS(2), .PARITY(2)) u_b (
        .clk(clk), .rst(rst), .rx(tx_b), .tx(tx_b), .transmit(transmit_b), .tx_data(tx_data_b),
        .received(received_b), .rx_data(rx_data_b), .is_receiving(is_receiving_b),
        .is_transmitting(is_transmitting_b), .recv_error(recv_error_b), .parity_error(parity_error_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (received_a)     begin n_rcv_a++; t_rcv_a = cyc; end
        if (recv_error_a)   n_err_a++;
        if (parity_error_a) n_perr_a++;
        if (is_receiving_a) n_isrx_a++;
        if (received_b)     n_rcv_b++;
        if (recv_error_b)   n_err_b++;
        if (parity_error_b) n_perr_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Reference frame: bit i of a frame carrying d (nd data bits).
    function automatic bit frame_bit(input logic [63:0] d, input int nd, input bit odd, input int i);
        if (i == 0) return 1'b0;
        if (i <= nd) return d[i-1];
        if (PON == 1 && i == nd + 1) return odd ^ (^d);
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_frame_a(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        for (int i = 0; i < NA; i++) begin
            bit b;
            b = frame_bit({56'd0, d}, 8, 1'b0, i);
            if (bad_par && PON == 1 && i == 9) b = ~b;
            if (bad_stop && i == NA - 1) b = 1'b0;
            rx_drv = b;
            repeat (TA) step();
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({tx_a, received_a, is_receiving_a, is_transmitting_a, recv_error_a, parity_error_a, rx_data_a} !== {1'b1, 5'b0, 8'h00}) begin
                n_bad++; $display("FAIL reset_a%0d: tx=%b rcv=%b isrx=%b istx=%b err=%b perr=%b data=%h, need tx=1 others 0",
                    k, tx_a, received_a, is_receiving_a, is_transmitting_a, recv_error_a, parity_error_a, rx_data_a);
            end
            n_cmp++;
            if ({tx_b, received_b, is_receiving_b, is_transmitting_b, recv_error_b, parity_error_b, rx_data_b} !== {1'b1, 5'b0, 64'h0}) begin
                n_bad++; $display("FAIL reset_b%0d: tx=%b rcv=%b isrx=%b istx=%b err=%b perr=%b data=%h, need tx=1 others 0",
                    k, tx_b, received_b, is_receiving_b, is_transmitting_b, recv_error_b, parity_error_b, rx_data_b);
            end
            rst = 1'b1;
            repeat (5) step();
        end
    endtask

    // Checks A's tx waveform bit by bit; called just after the acceptance edge.
    // With poke set, a transmit request with different data is made mid-frame.
    task automatic check_tx_a(input logic [7:0] d, input bit poke);
        for (int i = 0; i < NA; i++) begin
            bit e;
            int bad_tx, bad_busy;
            e = frame_bit({56'd0, d}, 8, 1'b0, i);
            bad_tx = 0; bad_busy = 0;
            for (int k = 0; k < TA; k++) begin
                if (tx_a !== e) bad_tx++;
                if (is_transmitting_a !== 1'b1) bad_busy++;
                transmit_a = (poke && i == 3 && k == 5);
                if (poke && i == 3 && k == 5) tx_data_a = ~d;
                step();
            end
            transmit_a = 1'b0;
            n_cmp++;
            if (bad_tx != 0 || bad_busy != 0) begin
                n_bad++; $display("FAIL tx_bit%0d data=%h: %0d cycles tx!=%b, %0d cycles not busy, need 0/0", i, d, bad_tx, e, bad_busy);
            end
        end
        n_cmp++;
        if ({tx_a, is_transmitting_a} !== 2'b10) begin
            n_bad++; $display("FAIL tx_end data=%h: tx=%b busy=%b, need tx=1 busy=0", d, tx_a, is_transmitting_a);
        end
        repeat (5) step();
        n_cmp++;
        if (is_transmitting_a !== 1'b0) begin
            n_bad++; $display("FAIL tx_no_queue data=%h: busy=%b, need 0", d, is_transmitting_a);
        end
    endtask

    task automatic test_tx_frames();
        logic [7:0] w [4];
        w[0] = 8'hA5; w[1] = 8'($urandom); w[2] = 8'($urandom); w[3] = 8'($urandom);
        loop_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tx_data_a = w[j]; transmit_a = 1'b1;
            step();
            transmit_a = 1'b0;
            check_tx_a(w[j], j == 1);
            repeat ($urandom_range(0, 5)) step();
        end
    endtask

    task automatic test_rx_random();
        loop_a = 1'b0;
        for (int j = 0; j < 5; j++) begin
            logic [7:0] d;
            int r0, e0, p0, t0, lat, base;
            d = 8'($urandom);
            repeat ($urandom_range(1, 40)) step();
            r0 = n_rcv_a; e0 = n_err_a; p0 = n_perr_a; t0 = cyc;
            drive_frame_a(d, 1'b0, 1'b0);
            repeat (4) step();
            n_cmp++;
            if (n_rcv_a - r0 != 1 || n_err_a - e0 != 0 || n_perr_a - p0 != 0) begin
                n_bad++; $display("FAIL rx_pulses data=%h: rcv=%0d err=%0d perr=%0d, need 1/0/0", d, n_rcv_a - r0, n_err_a - e0, n_perr_a - p0);
            end
            n_cmp++;
            if (rx_data_a !== d) begin
                n_bad++; $display("FAIL rx_data: got %h, need %h", rx_data_a, d);
            end
            lat  = t_rcv_a - t0;
            base = (NA - 1) * TA + 8 * BA + 2;
            n_cmp++;
            if (lat < base - BA || lat > base + BA) begin
                n_bad++; $display("FAIL rx_latency: got %0d cycles, need %0d..%0d", lat, base - BA, base + BA);
            end
        end
    endtask

    task automatic test_framing_error();
        logic [7:0] w, v;
        int r0, e0;
        loop_a = 1'b0;
        w = 8'($urandom);
        if (w == 8'h3C) w = 8'hC3;
        drive_frame_a(w, 1'b0, 1'b0);
        repeat (4) step();
        r0 = n_rcv_a; e0 = n_err_a;
        drive_frame_a(8'h3C, 1'b0, 1'b1);
        repeat (TA) step();
        n_cmp++;
        if (n_err_a - e0 != 1 || n_rcv_a - r0 != 0) begin
            n_bad++; $display("FAIL frame_err_pulses: err=%0d rcv=%0d, need 1/0", n_err_a - e0, n_rcv_a - r0);
        end
        n_cmp++;
        if (rx_data_a !== w) begin
            n_bad++; $display("FAIL frame_err_hold: rx_data=%h, need %h", rx_data_a, w);
        end
        // receiver must re-arm once the line is back high
        v = 8'($urandom);
        r0 = n_rcv_a;
        drive_frame_a(v, 1'b0, 1'b0);
        repeat (4) step();
        n_cmp++;
        if (n_rcv_a - r0 != 1 || rx_data_a !== v) begin
            n_bad++; $display("FAIL frame_err_rearm: rcv=%0d data=%h, need 1/%h", n_rcv_a - r0, rx_data_a, v);
        end
    endtask

    task automatic test_glitch();
        int r0, e0, i0;
        loop_a = 1'b0;
        r0 = n_rcv_a; e0 = n_err_a; i0 = n_isrx_a;
        rx_drv = 1'b0;
        repeat (4 * BA) step();
        rx_drv = 1'b1;
        repeat (3 * TA) step();
        n_cmp++;
        if (n_isrx_a - i0 == 0) begin
            n_bad++; $display("FAIL glitch_seen: is_receiving high for %0d cycles, need >0", n_isrx_a - i0);
        end
        n_cmp++;
        if (is_receiving_a !== 1'b0 || n_rcv_a - r0 != 0 || n_err_a - e0 != 0) begin
            n_bad++; $display("FAIL glitch_drop: isrx=%b rcv=%0d err=%0d, need 0/0/0", is_receiving_a, n_rcv_a - r0, n_err_a - e0);
        end
    endtask

    task automatic test_parity();
`ifdef UART_WIDE_PARITY_EN
        int r0, p0;
        loop_a = 1'b0;
        drive_frame_a(8'hE1, 1'b0, 1'b0);
        repeat (4) step();
        r0 = n_rcv_a; p0 = n_perr_a;
        drive_frame_a(8'h07, 1'b1, 1'b0);
        repeat (4) step();
        n_cmp++;
        if (n_perr_a - p0 != 1 || n_rcv_a - r0 != 0 || rx_data_a !== 8'hE1) begin
            n_bad++; $display("FAIL parity_bad: perr=%0d rcv=%0d data=%h, need 1/0/e1", n_perr_a - p0, n_rcv_a - r0, rx_data_a);
        end
        r0 = n_rcv_a; p0 = n_perr_a;
        drive_frame_a(8'h07, 1'b0, 1'b0);
        repeat (4) step();
        n_cmp++;
        if (n_perr_a - p0 != 0 || n_rcv_a - r0 != 1 || rx_data_a !== 8'h07) begin
            n_bad++; $display("FAIL parity_good: perr=%0d rcv=%0d data=%h, need 0/1/07", n_perr_a - p0, n_rcv_a - r0, rx_data_a);
        end
`else
        n_cmp++;
        if (n_perr_a != 0 || n_perr_b != 0 || parity_error_a !== 1'b0) begin
            n_bad++; $display("FAIL parity_off: perr pulses a=%0d b=%0d, need 0", n_perr_a, n_perr_b);
        end
`endif
    endtask

    task automatic test_loopback64();
        logic [63:0] w [3];
        w[0] = 64'h0123456789ABCDEF;
        w[1] = {$urandom, $urandom};
        w[2] = {$urandom, $urandom};
        for (int j = 0; j < 3; j++) begin
            int r0, e0, p0, n;
            r0 = n_rcv_b; e0 = n_err_b; p0 = n_perr_b;
            tx_data_b = w[j]; transmit_b = 1'b1;
            step();
            transmit_b = 1'b0;
            n = 0;
            while (is_transmitting_b && n < NB * 16 + 50) begin n++; step(); end
            n_cmp++;
            if (n != NB * 16) begin
                n_bad++; $display("FAIL b_busy_len: got %0d cycles, need %0d", n, NB * 16);
            end
            repeat (4) step();
            n_cmp++;
            if (n_rcv_b - r0 != 1 || n_err_b - e0 != 0 || n_perr_b - p0 != 0 || rx_data_b !== w[j]) begin
                n_bad++; $display("FAIL b_loopback: rcv=%0d err=%0d perr=%0d data=%h, need 1/0/0/%h",
                    n_rcv_b - r0, n_err_b - e0, n_perr_b - p0, rx_data_b, w[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        int r0, e0, n, gap;
        loop_a = 1'b1;
        w0 = 8'($urandom); w1 = ~w0;
        r0 = n_rcv_a; e0 = n_err_a;
        tx_data_a = w0; transmit_a = 1'b1;
        step();
        tx_data_a = w1;
        n = 0;
        while (is_transmitting_a && n < NA * TA + 50) begin n++; step(); end
        n_cmp++;
        if (n != NA * TA) begin
            n_bad++; $display("FAIL b2b_len: got %0d cycles, need %0d", n, NA * TA);
        end
        n_cmp++;
        if (n_rcv_a - r0 != 1 || rx_data_a !== w0) begin
            n_bad++; $display("FAIL b2b_first: rcv=%0d data=%h, need 1/%h", n_rcv_a - r0, rx_data_a, w0);
        end
        gap = 0;
        while (!is_transmitting_a && gap < 10) begin gap++; step(); end
        transmit_a = 1'b0;
        n_cmp++;
        if (gap != 1) begin
            n_bad++; $display("FAIL b2b_gap: idle %0d cycles, need 1", gap);
        end
        n = 0;
        while (is_transmitting_a && n < NA * TA + 50) begin n++; step(); end
        repeat (4) step();
        n_cmp++;
        if (n_rcv_a - r0 != 2 || n_err_a - e0 != 0 || rx_data_a !== w1) begin
            n_bad++; $display("FAIL b2b_second: rcv=%0d err=%0d data=%h, need 2/0/%h", n_rcv_a - r0, n_err_a - e0, rx_data_a, w1);
        end
        loop_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        int r0, e0, p0, rb0, eb0, n;
        loop_a = 1'b1;
        tx_data_a = 8'($urandom); tx_data_b = {$urandom, $urandom};
        transmit_a = 1'b1; transmit_b = 1'b1;
        step();
        transmit_a = 1'b0; transmit_b = 1'b0;
        repeat (3 * TA + TA / 2) step();
        n_cmp++;
        if ({is_transmitting_a, is_receiving_a, is_transmitting_b, is_receiving_b} !== 4'b1111) begin
            n_bad++; $display("FAIL midreset_busy: a tx/rx=%b%b b tx/rx=%b%b, need 1111",
                is_transmitting_a, is_receiving_a, is_transmitting_b, is_receiving_b);
        end
        r0 = n_rcv_a; e0 = n_err_a; p0 = n_perr_a; rb0 = n_rcv_b; eb0 = n_err_b;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({tx_a, received_a, is_receiving_a, is_transmitting_a, recv_error_a, parity_error_a, rx_data_a} !== {1'b1, 5'b0, 8'h00}) begin
            n_bad++; $display("FAIL midreset_a: tx=%b isrx=%b istx=%b data=%h, need tx=1 others 0", tx_a, is_receiving_a, is_transmitting_a, rx_data_a);
        end
        n_cmp++;
        if ({tx_b, received_b, is_receiving_b, is_transmitting_b, recv_error_b, parity_error_b, rx_data_b} !== {1'b1, 5'b0, 64'h0}) begin
            n_bad++; $display("FAIL midreset_b: tx=%b isrx=%b istx=%b data=%h, need tx=1 others 0", tx_b, is_receiving_b, is_transmitting_b, rx_data_b);
        end
        repeat (3) step();
        rst = 1'b1;
        repeat (2 * TA) step();
        n_cmp++;
        if (n_rcv_a != r0 || n_err_a != e0 || n_perr_a != p0 || n_rcv_b != rb0 || n_err_b != eb0) begin
            n_bad++; $display("FAIL midreset_pulses: a rcv/err/perr=%0d/%0d/%0d b rcv/err=%0d/%0d, need none",
                n_rcv_a - r0, n_err_a - e0, n_perr_a - p0, n_rcv_b - rb0, n_err_b - eb0);
        end
        tx_data_a = 8'h5A; transmit_a = 1'b1;
        step();
        transmit_a = 1'b0;
        n = 0;
        while (is_transmitting_a && n < NA * TA + 50) begin n++; step(); end
        repeat (4) step();
        n_cmp++;
        if (n_rcv_a - r0 != 1 || n_err_a - e0 != 0 || rx_data_a !== 8'h5A) begin
            n_bad++; $display("FAIL midreset_after: rcv=%0d err=%0d data=%h, need 1/0/5a", n_rcv_a - r0, n_err_a - e0, rx_data_a);
        end
        loop_a = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rx_drv = 1'b1; loop_a = 1'b0;
        transmit_a = 1'b0; transmit_b = 1'b0; tx_data_a = '0; tx_data_b = '0;
        test_reset();
        test_tx_frames();
        test_rx_random();
        test_framing_error();
        test_glitch();
        test_parity();
        test_loopback64();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
